fifo_pack_reader: RTL



---
 rtl/fifo_pack_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_pack_reader.sv
// Show-ahead FIFO consumer: packs PACK_NUM narrow entries into one wide valid/ready beat,
// flushing a partial pack early on idle timeout or an explicit flush request.
module fifo_pack_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_NUM   = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]        fifo_read_data_i,
  output logic                         fifo_read_en_o,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PACK_NUM*DATA_WIDTH-1:0] out_data_o,
  output logic [PACK_NUM-1:0]          out_mask_o,
  output logic                         busy_o
);

  localparam int unsigned IDX_W = $clog2(PACK_NUM + 1);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned OUT_W = PACK_NUM * DATA_WIDTH;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic [PACK_NUM-1:0] mask_q, mask_d;
  logic                busy_q, busy_d;
  logic                timeout_hit;

  // Pop only while filling; held low during reset so the FIFO is never touched.
  assign fifo_read_en_o = (state_q == FILL) & ~fifo_empty_i & rst_n;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state, lane fill and idle-timer logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;

    unique case (state_q)
      FILL: begin
        if (fifo_read_en_o) begin
          for (int unsigned k = 0; k < PACK_NUM; k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data_i;
              mask_d[k] = 1'b1;
            end
          end
          cnt_d = '0;
          if (idx_q == IDX_W'(PACK_NUM - 1)) begin
            idx_d   = '0;
            state_d = SEND;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            // A flush arriving with a pop keeps the popped entry in this pack.
            if (flush_i) state_d = SEND;
          end
        end else if (idx_q != '0) begin
          if (flush_i || timeout_hit) begin
            state_d = SEND;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      SEND: begin
        if (out_ready_i) begin
          state_d = FILL;
          idx_d   = '0;
          cnt_d   = '0;
          data_d  = '0;
          mask_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase

    busy_d = (idx_d != '0) || (state_d == SEND);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = data_q;
  assign out_mask_o  = mask_q;
  assign busy_o      = busy_q;

endmodule
